axi_txn_latency_monitor: RTL and testbench

- Passive monitor that consumes the per-transaction handshake strobes (tt_arvalid/tt_rlast/tt_awvalid/tt_bvalid and their IDs) that the single-engine action derives from its host-memory AXI master.
- Timestamps every accepted read/write address per AXI ID and measures latency to the matching last-read-beat / write response.
- Accumulates count, sum, min, max and outstanding depth per direction, and flags protocol anomalies.
- Outputs feed the AXI-Lite register hub for software readout.

---
 rtl/axi_txn_latency_monitor.sv | 159 +++++++++++++++
 tb/tb_axi_txn_latency_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_txn_latency_monitor.sv
// Passive AXI transaction latency monitor: timestamps issued read/write addresses per ID and
// accumulates completion latency statistics, outstanding depth and protocol anomaly flags.
module axi_txn_latency_monitor #(
  parameter int unsigned ID_WIDTH  = 5,
  parameter int unsigned TS_WIDTH  = 32,
  parameter int unsigned LAT_WIDTH = 16,
  parameter int unsigned SUM_WIDTH = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 tt_arvalid,
  input  logic [ID_WIDTH-1:0]  tt_arid,
  input  logic                 tt_rlast,
  input  logic [ID_WIDTH-1:0]  tt_rid,
  input  logic                 tt_awvalid,
  input  logic [ID_WIDTH-1:0]  tt_awid,
  input  logic                 tt_bvalid,
  input  logic [ID_WIDTH-1:0]  tt_bid,
  output logic [31:0]          rd_count,
  output logic [31:0]          wr_count,
  output logic [SUM_WIDTH-1:0] rd_lat_sum,
  output logic [SUM_WIDTH-1:0] wr_lat_sum,
  output logic [LAT_WIDTH-1:0] rd_lat_min,
  output logic [LAT_WIDTH-1:0] wr_lat_min,
  output logic [LAT_WIDTH-1:0] rd_lat_max,
  output logic [LAT_WIDTH-1:0] wr_lat_max,
  output logic [ID_WIDTH:0]    rd_outstanding,
  output logic [ID_WIDTH:0]    wr_outstanding,
  output logic [1:0]           err_id_reuse,
  output logic [1:0]           err_orphan,
  output logic                 monitor_idle
);

  localparam int unsigned Depth = 2 ** ID_WIDTH;
  localparam int unsigned OutW  = ID_WIDTH + 1;

  logic [TS_WIDTH-1:0] ts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q <= '0;
    end else if (clear) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
    end
  end

  // Index 0 is the read direction, index 1 the write direction.
  logic [1:0]                iss, cmp;
  logic [1:0][ID_WIDTH-1:0]  iss_id, cmp_id;
  logic [1:0][31:0]          count;
  logic [1:0][SUM_WIDTH-1:0] lat_sum;
  logic [1:0][LAT_WIDTH-1:0] lat_min, lat_max;
  logic [1:0][OutW-1:0]      outstanding;
  logic [1:0]                reuse, orphan;

  assign iss    = {tt_awvalid, tt_arvalid};
  assign cmp    = {tt_bvalid, tt_rlast};
  assign iss_id = {tt_awid, tt_arid};
  assign cmp_id = {tt_bid, tt_rid};

  for (genvar d = 0; d < 2; d++) begin : g_dir
    logic [Depth-1:0]     valid_q, valid_d;
    logic [TS_WIDTH-1:0]  ts_tab_q [Depth];
    logic                 same_id, hit, orphan_ev, reuse_ev, open_ev;
    logic [TS_WIDTH-1:0]  lat_full;
    logic [LAT_WIDTH-1:0] lat_sat;
    logic [32:0]          count_inc;
    logic [SUM_WIDTH:0]   sum_inc;
    logic [31:0]          count_q;
    logic [SUM_WIDTH-1:0] sum_q;
    logic [LAT_WIDTH-1:0] min_q, max_q;
    logic [OutW-1:0]      out_q;
    logic                 reuse_q, orphan_q;

    always_comb begin
      same_id   = (iss_id[d] == cmp_id[d]);
      hit       = ~clear & cmp[d] & valid_q[cmp_id[d]];
      orphan_ev = ~clear & cmp[d] & ~valid_q[cmp_id[d]];
      // A same-cycle completion on the same ID frees the entry before the issue reuses it.
      reuse_ev  = ~clear & iss[d] & valid_q[iss_id[d]] & ~(cmp[d] & same_id);
      open_ev   = ~clear & iss[d] & (~valid_q[iss_id[d]] | (cmp[d] & same_id));
      lat_full  = ts_q - ts_tab_q[cmp_id[d]];
      lat_sat   = (lat_full > TS_WIDTH'({LAT_WIDTH{1'b1}})) ? '1 : lat_full[LAT_WIDTH-1:0];
      count_inc = {1'b0, count_q} + 33'd1;
      sum_inc   = {1'b0, sum_q} + (SUM_WIDTH + 1)'(lat_full);
      valid_d   = valid_q;
      if (hit) valid_d[cmp_id[d]] = 1'b0;
      if (~clear & iss[d]) valid_d[iss_id[d]] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q  <= '0;
        count_q  <= '0;
        sum_q    <= '0;
        min_q    <= '1;
        max_q    <= '0;
        out_q    <= '0;
        reuse_q  <= 1'b0;
        orphan_q <= 1'b0;
      end else if (clear) begin
        valid_q  <= '0;
        count_q  <= '0;
        sum_q    <= '0;
        min_q    <= '1;
        max_q    <= '0;
        out_q    <= '0;
        reuse_q  <= 1'b0;
        orphan_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
        if (hit) begin
          count_q <= count_inc[32] ? '1 : count_inc[31:0];
          sum_q   <= sum_inc[SUM_WIDTH] ? '1 : sum_inc[SUM_WIDTH-1:0];
          if (lat_sat < min_q) min_q <= lat_sat;
          if (lat_sat > max_q) max_q <= lat_sat;
        end
        if (open_ev && !hit) begin
          out_q <= out_q + OutW'(1);
        end else if (!open_ev && hit) begin
          out_q <= out_q - OutW'(1);
        end
        if (reuse_ev)  reuse_q  <= 1'b1;
        if (orphan_ev) orphan_q <= 1'b1;
      end
    end

    // Timestamps are only meaningful while the matching valid bit is set, so no reset.
    always_ff @(posedge clk) begin
      if (~clear & iss[d]) ts_tab_q[iss_id[d]] <= ts_q;
    end

    assign count[d]       = count_q;
    assign lat_sum[d]     = sum_q;
    assign lat_min[d]     = min_q;
    assign lat_max[d]     = max_q;
    assign outstanding[d] = out_q;
    assign reuse[d]       = reuse_q;
    assign orphan[d]      = orphan_q;
  end

  assign rd_count       = count[0];
  assign wr_count       = count[1];
  assign rd_lat_sum     = lat_sum[0];
  assign wr_lat_sum     = lat_sum[1];
  assign rd_lat_min     = lat_min[0];
  assign wr_lat_min     = lat_min[1];
  assign rd_lat_max     = lat_max[0];
  assign wr_lat_max     = lat_max[1];
  assign rd_outstanding = outstanding[0];
  assign wr_outstanding = outstanding[1];
  assign err_id_reuse   = reuse;
  assign err_orphan     = orphan;
  assign monitor_idle   = (outstanding[0] == '0) && (outstanding[1] == '0);

endmodule

// File: tb/tb_axi_txn_latency_monitor.sv
// Self-checking bench: directed scenarios plus random strobes compared every cycle against a
// transaction-level model (open-transaction table keyed by ID, cycle-count latencies).
module tb_axi_txn_latency_monitor;

  localparam int unsigned IdW  = 5;
  localparam int unsigned Nid  = 32;
  localparam longint unsigned LatMax = 65535;

  logic        clk, rst, clear;
  logic        tt_arvalid, tt_rlast, tt_awvalid, tt_bvalid;
  logic [4:0]  tt_arid, tt_rid, tt_awid, tt_bid;
  logic [31:0] rd_count, wr_count;
  logic [47:0] rd_lat_sum, wr_lat_sum;
  logic [15:0] rd_lat_min, wr_lat_min, rd_lat_max, wr_lat_max;
  logic [5:0]  rd_outstanding, wr_outstanding;
  logic [1:0]  err_id_reuse, err_orphan;
  logic        monitor_idle;

  axi_txn_latency_monitor dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .tt_arvalid     (tt_arvalid),
    .tt_arid        (tt_arid),
    .tt_rlast       (tt_rlast),
    .tt_rid         (tt_rid),
    .tt_awvalid     (tt_awvalid),
    .tt_awid        (tt_awid),
    .tt_bvalid      (tt_bvalid),
    .tt_bid         (tt_bid),
    .rd_count       (rd_count),
    .wr_count       (wr_count),
    .rd_lat_sum     (rd_lat_sum),
    .wr_lat_sum     (wr_lat_sum),
    .rd_lat_min     (rd_lat_min),
    .wr_lat_min     (wr_lat_min),
    .rd_lat_max     (rd_lat_max),
    .wr_lat_max     (wr_lat_max),
    .rd_outstanding (rd_outstanding),
    .wr_outstanding (wr_outstanding),
    .err_id_reuse   (err_id_reuse),
    .err_orphan     (err_orphan),
    .monitor_idle   (monitor_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: which IDs are open and the cycle they were issued in.
  bit              open_v [2][Nid];
  longint unsigned open_t [2][Nid];
  longint unsigned m_cnt [2], m_sum [2], m_min [2], m_max [2];
  bit [1:0]        m_reuse, m_orph;
  longint unsigned mts;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < Nid; i++) open_v[d][i] = 1'b0;
      m_cnt[d] = 0; m_sum[d] = 0; m_min[d] = LatMax; m_max[d] = 0;
    end
    m_reuse = '0; m_orph = '0; mts = 0;
  endtask

  function automatic longint unsigned n_open(input int d);
    longint unsigned n = 0;
    for (int i = 0; i < Nid; i++) n += open_v[d][i];
    return n;
  endfunction

  task automatic model_dir(input int d, input bit iss, input int iid, input bit cmp,
                           input int cid);
    longint unsigned lat, ls;
    if (cmp) begin
      if (open_v[d][cid]) begin
        lat = mts - open_t[d][cid];
        ls  = (lat > LatMax) ? LatMax : lat;
        m_cnt[d]++;
        m_sum[d] += lat;
        if (ls < m_min[d]) m_min[d] = ls;
        if (ls > m_max[d]) m_max[d] = ls;
        open_v[d][cid] = 1'b0;
      end else begin
        m_orph[d] = 1'b1;
      end
    end
    if (iss) begin
      if (open_v[d][iid]) m_reuse[d] = 1'b1;
      open_v[d][iid] = 1'b1;
      open_t[d][iid] = mts;
    end
  endtask

  task automatic compare_all();
    chk("rd_count", rd_count, m_cnt[0]);
    chk("wr_count", wr_count, m_cnt[1]);
    chk("rd_lat_sum", rd_lat_sum, m_sum[0]);
    chk("wr_lat_sum", wr_lat_sum, m_sum[1]);
    chk("rd_lat_min", rd_lat_min, m_min[0]);
    chk("wr_lat_min", wr_lat_min, m_min[1]);
    chk("rd_lat_max", rd_lat_max, m_max[0]);
    chk("wr_lat_max", wr_lat_max, m_max[1]);
    chk("rd_outstanding", rd_outstanding, n_open(0));
    chk("wr_outstanding", wr_outstanding, n_open(1));
    chk("err_id_reuse", err_id_reuse, m_reuse);
    chk("err_orphan", err_orphan, m_orph);
    chk("monitor_idle", monitor_idle, (n_open(0) == 0 && n_open(1) == 0));
  endtask

  // One clock cycle: drive strobes, let the edge happen, advance the model, compare.
  task automatic step(input bit arv, input int arid, input bit rl, input int rid,
                      input bit awv, input int awid, input bit bv, input int bid,
                      input bit clr);
    tt_arvalid = arv; tt_arid = 5'(arid); tt_rlast  = rl; tt_rid = 5'(rid);
    tt_awvalid = awv; tt_awid = 5'(awid); tt_bvalid = bv; tt_bid = 5'(bid);
    clear = clr;
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else begin
      model_dir(0, arv, arid, rl, rid);
      model_dir(1, awv, awid, bv, bid);
      mts++;
    end
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_clear();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    tt_arvalid = 0; tt_rlast = 0; tt_awvalid = 0; tt_bvalid = 0;
    tt_arid = 0; tt_rid = 0; tt_awid = 0; tt_bid = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    chk("reset_min_literal", rd_lat_min, 16'hFFFF);
    chk("reset_idle_literal", monitor_idle, 1);
    rst = 1'b0;

    // Single read, latency 15.
    step(1, 3, 0, 0, 0, 0, 0, 0, 0);
    idle(14);
    step(0, 0, 1, 3, 0, 0, 0, 0, 0);
    chk("s1_count", rd_count, 1);
    chk("s1_sum", rd_lat_sum, 15);
    chk("s1_min", rd_lat_min, 15);
    chk("s1_max", rd_lat_max, 15);
    chk("s1_out", rd_outstanding, 0);

    // Three writes completed out of order.
    do_clear();
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 2, 0, 0, 0);
    chk("s2_peak_out", wr_outstanding, 3);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("s2_count", wr_count, 3);
    chk("s2_sum", wr_lat_sum, 15);
    chk("s2_min", wr_lat_min, 3);
    chk("s2_max", wr_lat_max, 6);

    // Same-ID issue and completion in one cycle.
    do_clear();
    step(1, 7, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    step(1, 7, 1, 7, 0, 0, 0, 0, 0);
    chk("s3_max", rd_lat_max, 4);
    chk("s3_out", rd_outstanding, 1);
    chk("s3_reuse", err_id_reuse, 0);
    chk("s3_orphan", err_orphan, 0);

    // ID reuse and orphan completion.
    do_clear();
    step(1, 5, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0, 0, 0, 0, 0);
    chk("s4_reuse", err_id_reuse, 2'b01);
    chk("s4_out", rd_outstanding, 1);
    step(0, 0, 1, 9, 0, 0, 0, 0, 0);
    chk("s4_orphan", err_orphan, 2'b01);
    chk("s4_reuse_sticky", err_id_reuse, 2'b01);

    // Latency beyond the min/max field width.
    do_clear();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(69999);
    step(0, 0, 1, 1, 0, 0, 0, 0, 0);
    chk("s5_max", rd_lat_max, 16'hFFFF);
    chk("s5_sum", rd_lat_sum, 70000);

    // Clear forgets open writes.
    do_clear();
    step(0, 0, 0, 0, 1, 4, 0, 0, 0);
    step(0, 0, 0, 0, 1, 6, 0, 0, 0);
    do_clear();
    step(0, 0, 0, 0, 0, 0, 1, 4, 0);
    step(0, 0, 0, 0, 0, 0, 1, 6, 0);
    chk("s6_count", wr_count, 0);
    chk("s6_orphan", err_orphan, 2'b10);

    // Random traffic with a narrow ID range for frequent collisions.
    do_clear();
    for (int i = 0; i < 3000; i++) begin
      int hi;
      hi = ($urandom_range(0, 9) == 0) ? 31 : 3;
      step($urandom_range(0, 2) == 0, $urandom_range(0, hi),
           $urandom_range(0, 2) == 0, $urandom_range(0, hi),
           $urandom_range(0, 2) == 0, $urandom_range(0, hi),
           $urandom_range(0, 2) == 0, $urandom_range(0, hi),
           $urandom_range(0, 199) == 0);
    end

    // Asynchronous reset mid-cycle.
    step(1, 2, 0, 0, 1, 3, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("rst_async_out", wr_outstanding, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 2, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 1, 2, 0, 0, 0, 0, 0);
    chk("post_rst_lat", rd_lat_sum, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
